bram_port_responder: RTL and testbench
======================================

Name: bram_port_responder

Overview:
- Responder (memory side) of the native BRAM port driven by the team's PL RAM controller blocks: en / we / addr / din / dout / rst.
- Holds an internal byte-addressed, word-organised RAM and answers reads with fixed latency.
- Applies byte-lane write enables, flags illegal accesses, and keeps access counters readable by AXI-Lite status registers.
- Serves as the PL-side BRAM target in standalone bring-up and as the bench model for the controller.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; must be a power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.
- INIT_ZERO, 1, 1 = RAM contents cleared by initial block; 0 = contents undefined.

Ports:
- clk  in  1  port clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  port enable from the initiator.
- we  in  4  byte write enables; bit i covers din[8i+7:8i].
- addr  in  32  byte address.
- din  in  32  write data from the initiator.
- dout  out  32  read data to the initiator.
- rst  in  1  port output reset, active-high, synchronous.
- stat_clr  in  1  synchronous pulse; clears counters and error flags.
- rd_cnt  out  32  accepted read count.
- wr_cnt  out  32  accepted write count (we != 0).
- err  out  1  sticky illegal-access flag.
- err_addr  out  32  address of the first illegal access since the last clear.

Behaviour:
- Reset (rst_n=0, async): dout=0, rd_cnt=0, wr_cnt=0, err=0, err_addr=0. RAM contents are NOT cleared.
- Word index: idx = (addr - BASE_ADDR) >> 2, using the low log2(DEPTH_WORDS) bits.
- Legal access: en=1, addr[1:0]==0, and BASE_ADDR <= addr < BASE_ADDR + DEPTH_WORDS*4. Unsigned 32-bit compare; no wrap-around.
- Write: en=1, we!=0, legal. On the clk edge, byte lanes with we[i]=1 are updated; other lanes are kept. wr_cnt increments by 1.
- Read: en=1, we==0, legal. dout = mem[idx] on the next edge, so latency is 1 cycle. rd_cnt increments by 1.
- Write cycle: dout is loaded with the OLD word (read-first). wr_cnt increments; rd_cnt does not.
- en=0: dout holds its value; no counter change.
- Illegal access (en=1, misaligned or out of range):
  - no RAM update;
  - dout <= 32'h0;
  - no counter increment;
  - err <= 1;
  - err_addr <= addr only if err was 0 (first error is captured).
- rst=1: dout <= 0 on that edge, overriding any read. A write in the same cycle still completes and is still counted.
- stat_clr=1: counters, err and err_addr are cleared. If an access occurs in the same cycle, the clear wins for that cycle; that access is not counted and not flagged.
- Counters saturate at 32'hFFFF_FFFF.
- Back-to-back accesses every cycle are supported, with no stall or bubble.
- Internal pipeline state: one registered read stage. Under OUTPUT_REG_EN, a second stage plus a valid bit.

Optional Feature:
- Macro: BRAM_PORT_RESPONDER_OUTPUT_REG_EN.
- Defined:
  - Adds an output register; read latency becomes 2 cycles.
  - The stage-1 word is captured into the output register on the next edge.
  - rst clears both stages.
  - Counters and error flags update at stage 1, so error timing is unchanged.
- Undefined: latency is 1 cycle, as described above.

Decomposition:
- Package bram_port_pkg:
  - DATA_W=32, BYTE_LANES=4, WORD_SHIFT=2;
  - a function computing address legality;
  - localparam ERR_NONE / ERR_RANGE / ERR_ALIGN codes (internal, for a future err_code port).
- Sub-module bram_word_array:
  - byte-enabled, read-first, single-port array with a registered output;
  - infers block RAM;
  - the parent holds the legality check, counters, error capture and optional output stage.

Test Plan:
- Write/read: write 0x0,0x2,…,0x1FE (+2 per word) to addresses BASE+0…BASE+0x3FC with we=4'hF, then read back. dout matches each word exactly 1 cycle after en (2 cycles with the macro). wr_cnt=256, rd_cnt=256, err=0.
- Byte lanes: write 0xFFFF_FFFF to BASE+0x10, then write 0x1234_5678 with we=4'b0101. A read of BASE+0x10 returns 0xFF34_FF78.
- Read-first: mem[BASE+0x20]=0xAAAA_AAAA; write 0x5555_5555 there with we=4'hF. dout=0xAAAA_AAAA after that edge; the following read returns 0x5555_5555.
- Illegal: access BASE+0x402 (misaligned), then BASE+DEPTH_WORDS*4 (out of range). err=1, err_addr=BASE+0x402, dout=0, counters unchanged, RAM unchanged.
- Controls: rst=1 during a read gives dout=0. stat_clr together with a write clears the counters to 0 and still updates the RAM.
- Async reset mid-burst: drop rst_n mid-burst. dout, counters and err go to 0 immediately. Previously written RAM data survives and reads back after reset release.

Source files
------------

// File: rtl/bram_port_pkg.sv
// bram_port_pkg: shared constants and the address-legality helper for the BRAM
// port responder.
//   DATA_W / BYTE_LANES / WORD_SHIFT : word geometry of the native BRAM port.
//   ERR_NONE / ERR_RANGE / ERR_ALIGN : access classification codes. These are
//                                      internal for now and reserved for a
//                                      future err_code port.
//   addr_check()                     : classifies one byte address against a
//                                      base address and a window size.
package bram_port_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BYTE_LANES = 4;
    localparam int unsigned WORD_SHIFT = 2;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;

    // span_bytes is 33 bits wide so that a window ending exactly at 2^32 is
    // representable. The offset compare is done only after addr >= base is
    // known, so the subtraction can never wrap.
    function automatic logic [1:0] addr_check(input logic [31:0] addr,
                                              input logic [31:0] base,
                                              input logic [32:0] span_bytes);
        logic [1:0]  code;
        logic [31:0] offset;
        offset = addr - base;
        code   = ERR_NONE;
        if (addr[WORD_SHIFT-1:0] != '0) begin
            code = ERR_ALIGN;
        end else if (addr < base) begin
            code = ERR_RANGE;
        end else if ({1'b0, offset} >= span_bytes) begin
            code = ERR_RANGE;
        end
        return code;
    endfunction

endpackage

// File: rtl/bram_word_array.sv
// bram_word_array: single-port, byte-enabled, read-first word array with a
// registered read output. It is written so that synthesis infers block RAM.
// Ports:
//   clk, rst_n : clock and async active-low reset. The reset clears only the
//                output register; the array contents are never reset.
//   rd_en      : load rdata with mem[idx] on this edge. A write issued in the
//                same cycle still returns the old word (read-first).
//   we         : per-byte-lane write enables. They apply to mem[idx].
//   idx        : word index.
//   wdata      : write data.
//   zero       : load rdata with 0 on this edge. Takes priority over rd_en.
//   rdata      : registered read data.
// INIT_ZERO = 1 gives the array an all-zero initial image. INIT_ZERO = 0 leaves
// the contents undefined at power-up.
module bram_word_array
    import bram_port_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter bit          INIT_ZERO   = 1'b1,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [BYTE_LANES-1:0] we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  zero,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS] =
        '{default: (INIT_ZERO ? {DATA_W{1'b0}} : {DATA_W{1'bx}})};

    logic [DATA_W-1:0] rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < BYTE_LANES; i++) begin
            if (we[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // The read samples the array before this edge's write lands, which gives
    // read-first behaviour.
    always_comb begin
        rdata_d = rdata_q;
        if (zero) begin
            rdata_d = '0;
        end else if (rd_en) begin
            rdata_d = mem[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bram_port_responder.sv
// bram_port_responder: memory-side responder for the native BRAM port
// (en/we/addr/din/dout/rst). It holds a byte-addressed, word-organised RAM,
// answers reads with a fixed latency, applies byte-lane writes, flags illegal
// accesses and keeps saturating access counters for status readout.
// Ports:
//   clk, rst_n    : port clock, async active-low reset (RAM contents survive).
//   en, we, addr  : access request; we != 0 selects a write.
//   din / dout    : write data in, read data out.
//   rst           : sync active-high output reset. A write in the same cycle
//                   still completes.
//   stat_clr      : sync clear of rd_cnt, wr_cnt, err and err_addr. It wins
//                   over any access counted or flagged in the same cycle.
//   rd_cnt/wr_cnt : accepted read / write counts, saturating.
//   err, err_addr : sticky illegal-access flag and the first offending address.
// Optional: define BRAM_PORT_RESPONDER_OUTPUT_REG_EN to add a second output
// stage. Read latency becomes 2 cycles; counter and error timing is unchanged.
// DEPTH_WORDS must be a power of two and at least 2. BASE_ADDR must be aligned
// to DEPTH_WORDS*4.
module bram_port_responder
    import bram_port_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter bit          INIT_ZERO   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [BYTE_LANES-1:0] we,
    input  logic [31:0]           addr,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout,
    input  logic                  rst,
    input  logic                  stat_clr,
    output logic [31:0]           rd_cnt,
    output logic [31:0]           wr_cnt,
    output logic                  err,
    output logic [31:0]           err_addr
);

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << WORD_SHIFT;

    logic [1:0]            chk_code;
    logic                  legal, illegal, is_wr, is_rd;
    logic [IDX_W-1:0]      idx;
    logic [BYTE_LANES-1:0] arr_we;
    logic                  arr_zero;
    logic [DATA_W-1:0]     s1_data;

    always_comb begin
        chk_code = addr_check(addr, BASE_ADDR, SPAN_BYTES);
        idx      = IDX_W'((addr - BASE_ADDR) >> WORD_SHIFT);
        legal    = en && (chk_code == ERR_NONE);
        illegal  = en && (chk_code != ERR_NONE);
        is_wr    = legal && (we != '0);
        is_rd    = legal && (we == '0);
        // rst only resets the output; a legal write still lands in the array.
        arr_we   = legal ? we : '0;
        arr_zero = rst || illegal;
    end

    bram_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .INIT_ZERO  (INIT_ZERO),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk  (clk),
        .rst_n(rst_n),
        .rd_en(legal),
        .we   (arr_we),
        .idx  (idx),
        .wdata(din),
        .zero (arr_zero),
        .rdata(s1_data)
    );

    // Status counters and error capture
    logic [31:0] rd_cnt_d, rd_cnt_q;
    logic [31:0] wr_cnt_d, wr_cnt_q;
    logic        err_d, err_q;
    logic [31:0] err_addr_d, err_addr_q;

    always_comb begin
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (stat_clr) begin
            rd_cnt_d   = '0;
            wr_cnt_d   = '0;
            err_d      = 1'b0;
            err_addr_d = '0;
        end else begin
            if (is_rd && (rd_cnt_q != '1)) begin
                rd_cnt_d = rd_cnt_q + 32'd1;
            end
            if (is_wr && (wr_cnt_q != '1)) begin
                wr_cnt_d = wr_cnt_q + 32'd1;
            end
            if (illegal) begin
                err_d = 1'b1;
                if (!err_q) begin
                    err_addr_d = addr;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign rd_cnt   = rd_cnt_q;
    assign wr_cnt   = wr_cnt_q;
    assign err      = err_q;
    assign err_addr = err_addr_q;

`ifdef BRAM_PORT_RESPONDER_OUTPUT_REG_EN
    // Second stage. s1_vld_q marks that stage 1 was reloaded on the last edge,
    // so stage 2 follows stage 1 one cycle later and otherwise holds.
    logic [DATA_W-1:0] out_d, out_q;
    logic              s1_vld_d, s1_vld_q;

    always_comb begin
        s1_vld_d = en && !rst;
        out_d    = out_q;
        if (rst) begin
            out_d = '0;
        end else if (s1_vld_q) begin
            out_d = s1_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            s1_vld_q <= s1_vld_d;
        end
    end

    assign dout = out_q;
`else
    assign dout = s1_data;
`endif

endmodule

// File: tb/tb_bram_port_responder.sv
`timescale 1ns/1ps
module tb_bram_port_responder;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int unsigned DEPTH = 256;
`ifdef BRAM_PORT_RESPONDER_OUTPUT_REG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n, en, rst, stat_clr, err;
    logic [3:0]  we;
    logic [31:0] addr, din, dout, rd_cnt, wr_cnt, err_addr;

    always #5 clk = ~clk;

    bram_port_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .INIT_ZERO  (1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .we      (we),
        .addr    (addr),
        .din     (din),
        .dout    (dout),
        .rst     (rst),
        .stat_clr(stat_clr),
        .rd_cnt  (rd_cnt),
        .wr_cnt  (wr_cnt),
        .err     (err),
        .err_addr(err_addr)
    );

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] model [DEPTH];
    int unsigned cyc, n_checks, n_fail;
    logic [31:0] exp_rd, exp_wr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic bit tb_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE) && (a < BASE + DEPTH * 4);
    endfunction

    function automatic int unsigned tb_idx(input logic [31:0] a);
        return ((a - BASE) >> 2) % DEPTH;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] w);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (w[k]) r[8*k +: 8] = d[8*k +: 8];
        end
        return r;
    endfunction

    // Advance one clock and compare every scoreboard entry that falls due.
    task automatic step();
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check("dout", dout, e.data);
        end
    endtask

    // One access cycle. The model, the expected counters and the scoreboard
    // are updated from the bench's own view of the port rules.
    task automatic access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                          input bit chk, input bit r, input bit clr);
        bit          ok;
        int unsigned i;
        logic [31:0] old;
        sb_t         e;
        ok  = tb_legal(a);
        i   = tb_idx(a);
        old = model[i];
        en = 1'b1; we = w; addr = a; din = d; rst = r; stat_clr = clr;
        if (ok && w != 4'h0) model[i] = merge(old, d, w);
        if (chk) begin
            e.due  = cyc + LAT;
            e.data = (r || !ok) ? 32'h0 : old;
            sb.push_back(e);
        end
        if (clr) begin
            exp_rd = 0;
            exp_wr = 0;
        end else if (ok) begin
            if (w != 4'h0) exp_wr++;
            else exp_rd++;
        end
        step();
        en = 1'b0; we = 4'h0; rst = 1'b0; stat_clr = 1'b0;
    endtask

    // Bounded wait for outstanding reads; leftovers count as a failure.
    task automatic drain();
        for (int k = 0; k < int'(LAT) + 2; k++) begin
            if (sb.size() != 0) step();
        end
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; we = 4'h0; addr = '0; din = '0; rst = 1'b0; stat_clr = 1'b0;
        cyc = 0; n_checks = 0; n_fail = 0; exp_rd = 0; exp_wr = 0;
        for (int k = 0; k < int'(DEPTH); k++) model[k] = 32'h0;

        #2 rst_n = 1'b0;
        #10;
        check("rst_dout", dout, 32'h0);
        check("rst_rd_cnt", rd_cnt, 32'h0);
        check("rst_wr_cnt", wr_cnt, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        check("rst_err_addr", err_addr, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill every word, then read all back-to-back.
        for (int k = 0; k < int'(DEPTH); k++) access(4'hF, BASE + 32'(4 * k), 32'(2 * k), 0, 0, 0);
        for (int k = 0; k < int'(DEPTH); k++) access(4'h0, BASE + 32'(4 * k), 32'h0, 1, 0, 0);
        drain();
        check("fill_wr_cnt", wr_cnt, 32'd256);
        check("fill_rd_cnt", rd_cnt, 32'd256);
        check("fill_err", {31'b0, err}, 32'h0);

        // Byte lanes
        access(4'hF, BASE + 32'h10, 32'hFFFF_FFFF, 0, 0, 0);
        access(4'b0101, BASE + 32'h10, 32'h1234_5678, 0, 0, 0);
        access(4'h0, BASE + 32'h10, 32'h0, 1, 0, 0);
        drain();
        check("lane_word", model[4], 32'hFF34_FF78);

        // Read-first: the write cycle returns the old word.
        access(4'hF, BASE + 32'h20, 32'hAAAA_AAAA, 0, 0, 0);
        access(4'hF, BASE + 32'h20, 32'h5555_5555, 1, 0, 0);
        access(4'h0, BASE + 32'h20, 32'h0, 1, 0, 0);
        drain();

        // Illegal: misaligned, then one past the end.
        access(4'h0, BASE + 32'h402, 32'h0, 1, 0, 0);
        access(4'hF, BASE + 32'h400, 32'hDEAD_BEEF, 1, 0, 0);
        drain();
        check("ill_err", {31'b0, err}, 32'h1);
        check("ill_err_addr", err_addr, BASE + 32'h402);
        check("ill_rd_cnt", rd_cnt, exp_rd);
        check("ill_wr_cnt", wr_cnt, exp_wr);
        access(4'h0, BASE, 32'h0, 1, 0, 0);
        access(4'h0, BASE + 32'h3FC, 32'h0, 1, 0, 0);
        drain();

        // rst overrides a read; a write under rst still lands and counts.
        access(4'h0, BASE + 32'h20, 32'h0, 1, 0, 0);
        drain();
        access(4'h0, BASE + 32'h10, 32'h0, 1, 1, 0);
        drain();
        access(4'hF, BASE + 32'h34, 32'h0BAD_CAFE, 1, 1, 0);
        drain();
        check("rstwr_wr_cnt", wr_cnt, exp_wr);

        // stat_clr together with a write: counters and flags clear, RAM updates.
        access(4'hF, BASE + 32'h30, 32'hCAFE_F00D, 0, 0, 1);
        check("clr_rd_cnt", rd_cnt, 32'h0);
        check("clr_wr_cnt", wr_cnt, 32'h0);
        check("clr_err", {31'b0, err}, 32'h0);
        check("clr_err_addr", err_addr, 32'h0);
        access(4'h0, BASE + 32'h30, 32'h0, 1, 0, 0);
        access(4'h0, BASE + 32'h34, 32'h0, 1, 0, 0);
        drain();
        check("post_clr_rd_cnt", rd_cnt, 32'd2);
        check("post_clr_wr_cnt", wr_cnt, 32'd0);

        // Async reset in the middle of a burst.
        access(4'h0, BASE + 32'h500, 32'h0, 1, 0, 0);
        access(4'h0, BASE + 32'h44, 32'h0, 1, 0, 0);
        access(4'h0, BASE + 32'h48, 32'h0, 1, 0, 0);
        access(4'h0, BASE + 32'h4C, 32'h0, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        check("ares_dout", dout, 32'h0);
        check("ares_rd_cnt", rd_cnt, 32'h0);
        check("ares_wr_cnt", wr_cnt, 32'h0);
        check("ares_err", {31'b0, err}, 32'h0);
        check("ares_err_addr", err_addr, 32'h0);
        exp_rd = 0;
        exp_wr = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        access(4'h0, BASE + 32'h30, 32'h0, 1, 0, 0);
        access(4'h0, BASE + 32'h34, 32'h0, 1, 0, 0);
        access(4'h0, BASE + 32'h10, 32'h0, 1, 0, 0);
        access(4'h0, BASE + 32'h20, 32'h0, 1, 0, 0);
        access(4'h0, BASE + 32'd400, 32'h0, 1, 0, 0);
        drain();
        check("ares_post_rd_cnt", rd_cnt, exp_rd);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
